// File: rtl/motion_cmd_gen_if.sv
// Command-path bundle between the key/speed source and the motion command
// generator: raw drive requests in, rate-limited command stream out.
interface motion_cmd_gen_if;
  logic       key_w;
  logic       key_a;
  logic       key_s;
  logic       key_d;
  logic [3:0] target_speed;
  logic [3:0] move_cmd;
  logic [3:0] speed_level;
  logic       valid;

  // Source side: drives requests, observes the command stream.
  modport master (
    output key_w, key_a, key_s, key_d, target_speed,
    input  move_cmd, speed_level, valid
  );

  // Generator side: consumes requests, produces the command stream.
  modport slave (
    input  key_w, key_a, key_s, key_d, target_speed,
    output move_cmd, speed_level, valid
  );
endinterface

// File: rtl/motion_cmd_gen.sv
// Motion command generator: synchronises and debounces W/A/S/D requests,
// ramps speed one level per ramp period, brakes to zero before any change
// of travel direction group, and keeps valid high while moving plus a hold
// window after stopping.
module motion_cmd_gen #(
  parameter int DEBOUNCE_CYCLES  = 50_000,
  parameter int RAMP_CYCLES      = 2_500_000,
  parameter int STOP_HOLD_CYCLES = 5_000_000,
  parameter int MAX_SPEED        = 9
) (
  input logic             clk,
  input logic             rst,
  motion_cmd_gen_if.slave bus
);

  localparam logic [3:0] CMD_STOP = 4'd8;
  localparam logic [3:0] MAX_LVL  = 4'(MAX_SPEED);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RAMP_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam int HOLD_W = $clog2(STOP_HOLD_CYCLES + 2);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_BRAKE} state_t;
  typedef enum logic [1:0] {G_FWD, G_REV, G_SPIN, G_STOP} group_t;

  // Key vector is packed as {w, a, s, d}.
  function automatic logic [3:0] decode_keys(input logic [3:0] k);
    case (k)
      4'b1000: return 4'd0;  // w
      4'b1100: return 4'd1;  // w+a
      4'b1001: return 4'd2;  // w+d
      4'b0010: return 4'd3;  // s
      4'b0100: return 4'd4;  // a
      4'b0001: return 4'd5;  // d
      4'b0110: return 4'd6;  // s+a
      4'b0011: return 4'd7;  // s+d
      default: return CMD_STOP;
    endcase
  endfunction

  function automatic group_t group_of(input logic [3:0] cmd);
    case (cmd)
      4'd0, 4'd1, 4'd2: return G_FWD;
      4'd3, 4'd6, 4'd7: return G_REV;
      4'd4, 4'd5:       return G_SPIN;
      default:          return G_STOP;
    endcase
  endfunction

  // ---------------------------------------------------------------- input path
  logic [3:0]      key_meta;
  logic [3:0]      key_sync;
  logic [3:0]      combo_q;
  logic [DB_W-1:0] stab_cnt;
  logic [DB_W-1:0] stab_nxt;
  logic [3:0]      req_cmd;

  // Two-flop synchroniser for the asynchronous key inputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta <= '0;
      key_sync <= '0;
    end else begin
      key_meta <= {bus.key_w, bus.key_a, bus.key_s, bus.key_d};
      key_sync <= key_meta;
    end
  end

  // Stability count: restarts at 1 on any change, saturates at the threshold.
  // NOTE: the default assignment first means every path writes stab_nxt, so no
  // latch is inferred.
  always_comb begin
    stab_nxt = stab_cnt;
    if (key_sync != combo_q)
      stab_nxt = DB_W'(1);
    else if (stab_cnt != DB_W'(DEBOUNCE_CYCLES))
      stab_nxt = stab_cnt + DB_W'(1);
  end

  // Accept the combination once it has been stable long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      combo_q  <= '0;
      stab_cnt <= '0;
      req_cmd  <= CMD_STOP;
    end else begin
      combo_q  <= key_sync;
      stab_cnt <= stab_nxt;
      if (stab_nxt == DB_W'(DEBOUNCE_CYCLES))
        req_cmd <= decode_keys(key_sync);
    end
  end

  // ---------------------------------------------------------------- motion FSM
  state_t            state, state_nxt;
  logic [3:0]        move_q, move_nxt;
  logic [3:0]        speed_q, speed_nxt;
  logic [RAMP_W-1:0] ramp_cnt, ramp_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              valid_q, valid_nxt;
  logic              first_q;   // first cycle after a state change
  logic [3:0]        tgt;
  logic              tick;
  logic              same_grp;

  assign tgt      = (bus.target_speed > MAX_LVL) ? MAX_LVL : bus.target_speed;
  assign tick     = (state != S_IDLE) && (ramp_cnt == RAMP_W'(RAMP_CYCLES - 1));
  assign same_grp = (group_of(req_cmd) == group_of(move_q));

  // Next-state and next-output decision; a group change outranks a ramp tick.
  always_comb begin
    state_nxt = state;
    move_nxt  = move_q;
    speed_nxt = speed_q;
    hold_nxt  = '0;
    case (state)
      S_IDLE: begin
        hold_nxt = (hold_cnt != '0) ? hold_cnt - HOLD_W'(1) : '0;
        if (req_cmd != CMD_STOP) begin
          state_nxt = S_RUN;
          move_nxt  = req_cmd;
          speed_nxt = '0;
          hold_nxt  = '0;
        end
      end
      S_RUN: begin
        if (!same_grp) begin
          state_nxt = S_BRAKE;
        end else begin
          move_nxt = req_cmd;
          if (tick) begin
            if (speed_q < tgt)      speed_nxt = speed_q + 4'd1;
            else if (speed_q > tgt) speed_nxt = speed_q - 4'd1;
          end
        end
      end
      S_BRAKE: begin
        if (same_grp) begin
          state_nxt = S_RUN;
          move_nxt  = req_cmd;
        end else if ((speed_q == '0) && (tick || first_q)) begin
          if (req_cmd == CMD_STOP) begin
            state_nxt = S_IDLE;
            move_nxt  = CMD_STOP;
            hold_nxt  = HOLD_W'(STOP_HOLD_CYCLES);
          end else begin
            state_nxt = S_RUN;
            move_nxt  = req_cmd;
          end
        end else if (tick) begin
          speed_nxt = speed_q - 4'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        move_nxt  = CMD_STOP;
        speed_nxt = '0;
      end
    endcase

    // Ramp counter restarts on every state entry and on each tick.
    if ((state_nxt != state) || (state == S_IDLE) || tick)
      ramp_nxt = '0;
    else
      ramp_nxt = ramp_cnt + RAMP_W'(1);

    valid_nxt = (state_nxt != S_IDLE) || (hold_nxt != '0);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      move_q   <= CMD_STOP;
      speed_q  <= '0;
      ramp_cnt <= '0;
      hold_cnt <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      move_q   <= move_nxt;
      speed_q  <= speed_nxt;
      ramp_cnt <= ramp_nxt;
      hold_cnt <= hold_nxt;
      valid_q  <= valid_nxt;
      first_q  <= (state_nxt != state);
    end
  end

  assign bus.move_cmd    = move_q;
  assign bus.speed_level = speed_q;
  assign bus.valid       = valid_q;

endmodule

// File: tb/tb_motion_cmd_gen.sv
// Bench for motion_cmd_gen: directed scenarios followed by random key/speed
// traffic, every cycle compared against a behavioural model of the command
// rules (request delay line, stability window, drive/brake/stop modes).
module tb_motion_cmd_gen;
  localparam int DEB  = 4;
  localparam int RAMP = 8;
  localparam int HOLD = 20;
  localparam int MAXS = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  motion_cmd_gen_if bus();

  motion_cmd_gen #(
    .DEBOUNCE_CYCLES (DEB),
    .RAMP_CYCLES     (RAMP),
    .STOP_HOLD_CYCLES(HOLD),
    .MAX_SPEED       (MAXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state. Modes: 0 stopped, 1 driving, 2 braking.
  int m_mode, m_cmd, m_spd, m_valid, m_hold, m_age, m_req;
  int d1, d2;           // key combination delayed through two samples
  int seen_q[$];        // last DEB synchronised combinations
  int cmd_lut[16];

  logic [3:0] good_keys[8] = '{4'b1000, 4'b1100, 4'b1001, 4'b0010,
                               4'b0100, 4'b0001, 4'b0110, 4'b0011};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int grp(input int c);
    if (c == 0 || c == 1 || c == 2) return 0;
    if (c == 3 || c == 6 || c == 7) return 1;
    if (c == 4 || c == 5) return 2;
    return 3;
  endfunction

  task automatic set_keys(input logic [3:0] k);
    bus.key_w = k[3];
    bus.key_a = k[2];
    bus.key_s = k[1];
    bus.key_d = k[0];
  endtask

  task automatic model_reset();
    m_mode = 0; m_cmd = 8; m_spd = 0; m_valid = 0;
    m_hold = 0; m_age = 0; m_req = 8; d1 = 0; d2 = 0;
    seen_q = {};
    for (int i = 0; i < DEB; i++) seen_q.push_back(0);
  endtask

  // One clock edge of the command rules, using the pre-edge request.
  task automatic model_step();
    int  tgt, seen;
    bit  tick, stable;
    if (rst) begin
      model_reset();
      return;
    end
    tgt  = (int'(bus.target_speed) > MAXS) ? MAXS : int'(bus.target_speed);
    tick = (m_age % RAMP) == RAMP - 1;
    case (m_mode)
      0: begin
        if (m_hold > 0) m_hold--;
        if (m_req != 8) begin
          m_mode = 1; m_cmd = m_req; m_spd = 0; m_age = 0;
        end else m_age++;
      end
      1: begin
        if (grp(m_req) != grp(m_cmd)) begin
          m_mode = 2; m_age = 0;
        end else begin
          m_cmd = m_req;
          if (tick && m_spd < tgt) m_spd++;
          else if (tick && m_spd > tgt) m_spd--;
          m_age++;
        end
      end
      default: begin
        if (grp(m_req) == grp(m_cmd)) begin
          m_mode = 1; m_cmd = m_req; m_age = 0;
        end else if (m_spd == 0 && (m_age == 0 || tick)) begin
          if (m_req == 8) begin
            m_mode = 0; m_cmd = 8; m_hold = HOLD;
          end else begin
            m_mode = 1; m_cmd = m_req;
          end
          m_age = 0;
        end else begin
          if (tick) m_spd--;
          m_age++;
        end
      end
    endcase
    m_valid = (m_mode != 0 || m_hold > 0) ? 1 : 0;

    seen = d2;
    d2   = d1;
    d1   = int'({bus.key_w, bus.key_a, bus.key_s, bus.key_d});
    seen_q.push_back(seen);
    void'(seen_q.pop_front());
    stable = 1'b1;
    foreach (seen_q[i]) if (seen_q[i] != seen) stable = 1'b0;
    if (stable) m_req = cmd_lut[seen];
  endtask

  // Advance n cycles; outputs compared on the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("move_cmd", 8'(bus.move_cmd), 8'(m_cmd));
      check("speed_level", 8'(bus.speed_level), 8'(m_spd));
      check("valid", 8'(bus.valid), 8'(m_valid));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) cmd_lut[i] = 8;
    cmd_lut[4'b1000] = 0; cmd_lut[4'b1100] = 1; cmd_lut[4'b1001] = 2;
    cmd_lut[4'b0010] = 3; cmd_lut[4'b0100] = 4; cmd_lut[4'b0001] = 5;
    cmd_lut[4'b0110] = 6; cmd_lut[4'b0011] = 7;
    model_reset();

    set_keys(4'b0000);
    bus.target_speed = 4'd0;
    rst = 1'b1;
    step(2);
    check("reset_move_cmd", 8'(bus.move_cmd), 8'd8);
    check("reset_speed", 8'(bus.speed_level), 8'd0);
    check("reset_valid", 8'(bus.valid), 8'd0);
    rst = 1'b0;
    step(3);

    // Short glitch on w never reaches the request.
    set_keys(4'b1000);
    step(3);
    set_keys(4'b0000);
    step(20);
    check("glitch_move_cmd", 8'(bus.move_cmd), 8'd8);
    check("glitch_valid", 8'(bus.valid), 8'd0);

    // w held, target 3: command after 2+4+1 cycles, then one level per tick.
    set_keys(4'b1000);
    bus.target_speed = 4'd3;
    step(6);
    check("w_before_accept", 8'(bus.move_cmd), 8'd8);
    step(1);
    check("w_accept_cmd", 8'(bus.move_cmd), 8'd0);
    check("w_accept_speed", 8'(bus.speed_level), 8'd0);
    check("w_accept_valid", 8'(bus.valid), 8'd1);
    step(8);
    check("ramp_1", 8'(bus.speed_level), 8'd1);
    step(8);
    check("ramp_2", 8'(bus.speed_level), 8'd2);
    step(8);
    check("ramp_3", 8'(bus.speed_level), 8'd3);
    step(16);
    check("ramp_hold_3", 8'(bus.speed_level), 8'd3);

    // Same-group change w -> w+a: no braking.
    set_keys(4'b1100);
    step(10);
    check("wa_cmd", 8'(bus.move_cmd), 8'd1);
    check("wa_speed", 8'(bus.speed_level), 8'd3);
    set_keys(4'b1000);
    step(10);
    check("back_w_cmd", 8'(bus.move_cmd), 8'd0);

    // Reversal w -> s: brake 3,2,1,0 while holding w, then s.
    set_keys(4'b0010);
    step(31);
    check("rev_brake_cmd", 8'(bus.move_cmd), 8'd0);
    check("rev_brake_speed", 8'(bus.speed_level), 8'd0);
    step(8);
    check("rev_switch_cmd", 8'(bus.move_cmd), 8'd3);
    step(24);
    check("rev_ramp_speed", 8'(bus.speed_level), 8'd3);

    // Stop from speed 2: brake, then stop with a 20-cycle valid hold.
    bus.target_speed = 4'd2;
    step(10);
    check("pre_stop_speed", 8'(bus.speed_level), 8'd2);
    set_keys(4'b0000);
    step(31);
    check("stop_cmd", 8'(bus.move_cmd), 8'd8);
    check("stop_valid_start", 8'(bus.valid), 8'd1);
    step(19);
    check("stop_valid_last", 8'(bus.valid), 8'd1);
    step(1);
    check("stop_valid_drop", 8'(bus.valid), 8'd0);

    // target 15 saturates at MAX_SPEED.
    set_keys(4'b1000);
    bus.target_speed = 4'd15;
    step(84);
    check("sat_speed", 8'(bus.speed_level), 8'd9);
    step(16);
    check("sat_speed_hold", 8'(bus.speed_level), 8'd9);

    // w+s is a stop request.
    set_keys(4'b1010);
    step(90);
    check("ws_stop_cmd", 8'(bus.move_cmd), 8'd8);
    check("ws_stop_speed", 8'(bus.speed_level), 8'd0);
    step(25);

    // Reset in the middle of a ramp.
    set_keys(4'b0001);
    bus.target_speed = 4'd5;
    step(27);
    check("pre_rst_speed", 8'(bus.speed_level), 8'd2);
    rst = 1'b1;
    step(1);
    check("midrst_cmd", 8'(bus.move_cmd), 8'd8);
    check("midrst_speed", 8'(bus.speed_level), 8'd0);
    check("midrst_valid", 8'(bus.valid), 8'd0);
    rst = 1'b0;
    set_keys(4'b0000);
    step(5);

    // Random key combinations, durations and targets.
    for (int seg = 0; seg < 70; seg++) begin
      if ($urandom_range(0, 9) < 7)
        set_keys(good_keys[$urandom_range(0, 7)]);
      else
        set_keys(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0)
        bus.target_speed = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      step($urandom_range(1, 60));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
